// File: rtl/demux_pkg.sv
// Shared helpers for the registered demultiplexer: selector width, flat-bus slicing,
// and the default width of the per-channel delivery counters.
package demux_pkg;

  localparam int CONT_BITS_DEF = 8;

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_canal.sv
// One output channel: single-entry holding register with valid flag, load-over-drain priority,
// and (with DEMUX_REG_CONTADORES_EN) a saturating delivery counter.
module demux_canal #(
  parameter int DATA_BITS = 4,
  parameter int CONT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 carga,
  input  logic [DATA_BITS-1:0] dato,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] salida,
  output logic                 valid
`ifdef DEMUX_REG_CONTADORES_EN
  , output logic [CONT_BITS-1:0] contador
`endif
);

  logic [DATA_BITS-1:0] dato_p1;
  logic                 vld_p1;
  logic                 entrega;

  assign entrega = vld_p1 && ready;

  // Stage p1: holding register; a load wins over a drain so a draining channel refills in place
  always_ff @(posedge clk) begin
    if (reset) begin
      dato_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (carga) begin
      dato_p1 <= dato;
      vld_p1  <= 1'b1;
    end else if (entrega) begin
      vld_p1  <= 1'b0;
    end
  end

  assign salida = vld_p1 ? dato_p1 : '0;
  assign valid  = vld_p1;

`ifdef DEMUX_REG_CONTADORES_EN
  logic [CONT_BITS-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p1 <= '0;
    end else if (entrega && (cnt_p1 != {CONT_BITS{1'b1}})) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign contador = cnt_p1;
`endif

endmodule

// File: rtl/demux_reg.sv
// Registered N-way demultiplexer with per-channel valid/ready backpressure.
// Optional per-channel delivery counters enabled by DEMUX_REG_CONTADORES_EN.
module demux_reg
  import demux_pkg::*;
#(
  parameter  int DATA_BITS   = 4,
  parameter  int NUM_SALIDAS = 4,
  parameter  int CONT_BITS   = CONT_BITS_DEF,
  localparam int SEL_BITS    = sel_bits(NUM_SALIDAS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enb,
  input  logic [DATA_BITS-1:0]             entrada,
  input  logic                             valid_entrada,
  input  logic [SEL_BITS-1:0]              selector,
  output logic                             ready_entrada,
  output logic [NUM_SALIDAS*DATA_BITS-1:0] salida,
  output logic [NUM_SALIDAS-1:0]           valid_salida,
  input  logic [NUM_SALIDAS-1:0]           ready_salida,
  output logic                             error_selector
`ifdef DEMUX_REG_CONTADORES_EN
  , output logic [NUM_SALIDAS*CONT_BITS-1:0] contadores
`endif
);

  localparam logic [SEL_BITS:0] NUM_S = NUM_SALIDAS[SEL_BITS:0];

  logic                   sel_ok;
  logic                   canal_lleno;
  logic                   acepta;
  logic [NUM_SALIDAS-1:0] carga;
  logic                   err_p1;

  assign sel_ok = ({1'b0, selector} < NUM_S);

  // Only the addressed channel can block the input; stalls elsewhere are invisible here
  always_comb begin
    canal_lleno = 1'b0;
    carga       = '0;
    for (int k = 0; k < NUM_SALIDAS; k++) begin
      if (sel_ok && (selector == SEL_BITS'(k))) begin
        canal_lleno = valid_salida[k] && !ready_salida[k];
        carga[k]    = acepta;
      end
    end
  end

  assign ready_entrada = enb && !canal_lleno;
  assign acepta        = valid_entrada && ready_entrada;

  // Stage p1: out-of-range words are swallowed and flagged for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      err_p1 <= 1'b0;
    end else begin
      err_p1 <= acepta && !sel_ok;
    end
  end

  assign error_selector = err_p1;

  for (genvar k = 0; k < NUM_SALIDAS; k++) begin : g_canal
    demux_canal #(
      .DATA_BITS (DATA_BITS),
      .CONT_BITS (CONT_BITS)
    ) u_canal (
      .clk      (clk),
      .reset    (reset),
      .carga    (carga[k]),
      .dato     (entrada),
      .ready    (ready_salida[k]),
      .salida   (salida[slice_lo(k, DATA_BITS) +: DATA_BITS]),
      .valid    (valid_salida[k])
`ifdef DEMUX_REG_CONTADORES_EN
      , .contador (contadores[slice_lo(k, CONT_BITS) +: CONT_BITS])
`endif
    );
  end

endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: a 4-channel instance for the main scenarios and a
// 3-channel instance for the out-of-range selector; counter checks under DEMUX_REG_CONTADORES_EN.
module tb_demux_reg;

  logic        clk = 1'b0;
  logic        reset;
  int          total = 0;
  int          bad = 0;

  // 4-channel instance
  logic        enb, valid_e, ready_e, err;
  logic [3:0]  entrada;
  logic [1:0]  sel;
  logic [15:0] salida;
  logic [3:0]  valid_s, ready_s;
  // 3-channel instance
  logic        enb3, valid_e3, ready_e3, err3;
  logic [3:0]  entrada3;
  logic [1:0]  sel3;
  logic [11:0] salida3;
  logic [2:0]  valid_s3, ready_s3;
`ifdef DEMUX_REG_CONTADORES_EN
  logic [7:0]  cont;
  logic [5:0]  cont3;
`endif

  always #5 clk = ~clk;

  demux_reg #(.DATA_BITS(4), .NUM_SALIDAS(4), .CONT_BITS(2)) dut (
    .clk(clk), .reset(reset), .enb(enb), .entrada(entrada), .valid_entrada(valid_e),
    .selector(sel), .ready_entrada(ready_e), .salida(salida), .valid_salida(valid_s),
    .ready_salida(ready_s), .error_selector(err)
`ifdef DEMUX_REG_CONTADORES_EN
    , .contadores(cont)
`endif
  );

  demux_reg #(.DATA_BITS(4), .NUM_SALIDAS(3), .CONT_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .enb(enb3), .entrada(entrada3), .valid_entrada(valid_e3),
    .selector(sel3), .ready_entrada(ready_e3), .salida(salida3), .valid_salida(valid_s3),
    .ready_salida(ready_s3), .error_selector(err3)
`ifdef DEMUX_REG_CONTADORES_EN
    , .contadores(cont3)
`endif
  );

  // Advance one edge; inputs are then changed 1ns after it and outputs checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enb = 1'b0; valid_e = 1'b0; entrada = '0; sel = '0; ready_s = '0;
    enb3 = 1'b0; valid_e3 = 1'b0; entrada3 = '0; sel3 = '0; ready_s3 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (valid_s !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", valid_s); end
    total++; if (salida !== 16'h0000) begin bad++; $display("FAIL reset_salida got=%h exp=0000", salida); end
    total++; if (err !== 1'b0 || err3 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", err, err3); end
  endtask

  task automatic test_basic();
    enb = 1'b1; ready_s = 4'hF;
    entrada = 4'hA; sel = 2'd2; valid_e = 1'b1;
    #1;
    total++; if (ready_e !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", ready_e); end
    tick();
    valid_e = 1'b0;
    #1;
    total++; if (valid_s !== 4'b0100) begin bad++; $display("FAIL basic_valid got=%b exp=0100", valid_s); end
    total++; if (salida !== 16'h0A00) begin bad++; $display("FAIL basic_salida got=%h exp=0a00", salida); end
    tick();
    total++; if (valid_s !== 4'b0000 || salida !== 16'h0000) begin bad++; $display("FAIL basic_drain got=%b/%h exp=0000/0000", valid_s, salida); end
  endtask

  task automatic test_stall();
    ready_s = 4'b1101;
    entrada = 4'h3; sel = 2'd1; valid_e = 1'b1;
    tick();
    entrada = 4'h5;
    #1;
    total++; if (ready_e !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", ready_e); end
    tick();
    total++; if (salida[7:4] !== 4'h3 || valid_s !== 4'b0010) begin bad++; $display("FAIL stall_hold got=%h/%b exp=3/0010", salida[7:4], valid_s); end
    entrada = 4'h7; sel = 2'd0;
    #1;
    total++; if (ready_e !== 1'b1) begin bad++; $display("FAIL stall_other_ready got=%b exp=1", ready_e); end
    tick();
    entrada = 4'h5; sel = 2'd1; ready_s = 4'hF;
    #1;
    total++; if (salida !== 16'h0037 || valid_s !== 4'b0011) begin bad++; $display("FAIL stall_both got=%h/%b exp=0037/0011", salida, valid_s); end
    total++; if (ready_e !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", ready_e); end
    tick();
    valid_e = 1'b0;
    #1;
    total++; if (salida !== 16'h0050 || valid_s !== 4'b0010) begin bad++; $display("FAIL stall_refill got=%h/%b exp=0050/0010", salida, valid_s); end
    tick();
    total++; if (valid_s !== 4'b0000) begin bad++; $display("FAIL stall_empty got=%b exp=0000", valid_s); end
  endtask

  task automatic test_back_to_back();
    ready_s = 4'hF; sel = 2'd3;
    for (int i = 0; i < 8; i++) begin
      entrada = 4'(i + 1); valid_e = 1'b1;
      #1;
      total++; if (ready_e !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, ready_e); end
      if (i > 0) begin
        total++;
        if (valid_s !== 4'b1000 || salida[15:12] !== 4'(i)) begin
          bad++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1000/%h", i, valid_s, salida[15:12], 4'(i));
        end
      end
      tick();
    end
    valid_e = 1'b0;
    #1;
    total++; if (valid_s !== 4'b1000 || salida[15:12] !== 4'h8) begin bad++; $display("FAIL b2b_last got=%b/%h exp=1000/8", valid_s, salida[15:12]); end
    tick();
    total++; if (valid_s !== 4'b0000) begin bad++; $display("FAIL b2b_empty got=%b exp=0000", valid_s); end
  endtask

  task automatic test_enb_reset();
    ready_s = 4'b1110; enb = 1'b1;
    entrada = 4'hC; sel = 2'd0; valid_e = 1'b1;
    tick();
    enb = 1'b0; entrada = 4'h9; sel = 2'd1; ready_s = 4'hF;
    #1;
    total++; if (ready_e !== 1'b0) begin bad++; $display("FAIL enb_ready got=%b exp=0", ready_e); end
    total++; if (salida !== 16'h000C || valid_s !== 4'b0001) begin bad++; $display("FAIL enb_hold got=%h/%b exp=000c/0001", salida, valid_s); end
    tick();
    total++; if (valid_s !== 4'b0000 || salida !== 16'h0000) begin bad++; $display("FAIL enb_drain got=%b/%h exp=0000/0000", valid_s, salida); end
    enb = 1'b1; ready_s = 4'b1011; entrada = 4'hE; sel = 2'd2;
    tick();
    valid_e = 1'b0;
    #1;
    total++; if (valid_s !== 4'b0100 || salida !== 16'h0E00) begin bad++; $display("FAIL full2 got=%b/%h exp=0100/0e00", valid_s, salida); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (valid_s !== 4'b0000 || salida !== 16'h0000 || err !== 1'b0) begin bad++; $display("FAIL midreset got=%b/%h/%b exp=0000/0000/0", valid_s, salida, err); end
    ready_s = 4'hF;
  endtask

  task automatic test_err_selector();
    enb3 = 1'b1; ready_s3 = 3'b011;
    entrada3 = 4'hB; sel3 = 2'd2; valid_e3 = 1'b1;
    tick();
    sel3 = 2'd3; entrada3 = 4'h4;
    #1;
    total++; if (ready_e3 !== 1'b1) begin bad++; $display("FAIL err_ready got=%b exp=1", ready_e3); end
    tick();
    valid_e3 = 1'b0;
    #1;
    total++; if (err3 !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", err3); end
    total++; if (valid_s3 !== 3'b100 || salida3 !== 12'hB00) begin bad++; $display("FAIL err_nochange got=%b/%h exp=100/b00", valid_s3, salida3); end
    tick();
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL err_oneshot got=%b exp=0", err3); end
    enb3 = 1'b0; valid_e3 = 1'b1;
    #1;
    total++; if (ready_e3 !== 1'b0) begin bad++; $display("FAIL err_enb_ready got=%b exp=0", ready_e3); end
    tick();
    valid_e3 = 1'b0;
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL err_enb_quiet got=%b exp=0", err3); end
  endtask

`ifdef DEMUX_REG_CONTADORES_EN
  task automatic test_contadores();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (cont !== 8'h00) begin bad++; $display("FAIL cnt_reset got=%h exp=00", cont); end
    enb = 1'b1; ready_s = 4'hF; sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      entrada = 4'(i + 2); valid_e = 1'b1;
      tick();
      if (i == 2) begin
        total++; if (cont !== 8'h08) begin bad++; $display("FAIL cnt_mid got=%h exp=08", cont); end
      end
    end
    valid_e = 1'b0;
    tick();
    total++; if (cont !== 8'h0C) begin bad++; $display("FAIL cnt_sat got=%h exp=0c", cont); end
    tick();
    total++; if (cont !== 8'h0C) begin bad++; $display("FAIL cnt_hold got=%h exp=0c", cont); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_enb_reset();
    test_err_selector();
`ifdef DEMUX_REG_CONTADORES_EN
    test_contadores();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Parametrised, registered N-way demultiplexer with valid/ready handshake on the input and on every output channel.
- Each channel has a one-entry holding register. A downstream consumer that stalls blocks only its own channel.
- Sits between the upstream data source and the per-lane consumers. Replaces the 4-way combinational demux wherever backpressure or a registered boundary is required.

Parameters:
- DATA_BITS, 4, width of one data word.
- NUM_SALIDAS, 4, number of output channels (>= 2; need not be a power of two).
- CONT_BITS, 8, width of each per-channel delivery counter (used only with the optional feature).
- SEL_BITS, $clog2(NUM_SALIDAS), local parameter, selector width; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  block enable; when low no new word is accepted, but channels keep draining.
- entrada  input  DATA_BITS  input data word.
- valid_entrada  input  1  entrada/selector qualified.
- selector  input  SEL_BITS  destination channel index.
- ready_entrada  output  1  block accepts the word this cycle.
- salida  output  NUM_SALIDAS*DATA_BITS  flattened channel data; channel k at bits [k*DATA_BITS +: DATA_BITS].
- valid_salida  output  NUM_SALIDAS  per-channel valid.
- ready_salida  input  NUM_SALIDAS  per-channel consumer ready.
- error_selector  output  1  one-cycle pulse after an out-of-range selector is accepted.

Behaviour:
- Reset (synchronous, active-high; a reset in the middle of an operation discards all held words):
  - all channel data registers = 0, valid_salida = 0, error_selector = 0, counters = 0.
- Selector range:
  - sel_ok = (selector < NUM_SALIDAS).
- ready_entrada (combinational):
  - = enb && (!sel_ok || !valid_salida[selector] || ready_salida[selector]).
  - It depends only on the selected channel; other channels' state is ignored.
- Accept:
  - Accept occurs when valid_entrada && ready_entrada.
  - If sel_ok, channel[selector] loads entrada and its valid_salida rises at the next edge. Latency is exactly 1 cycle.
  - A word sent to a free channel is accepted the same cycle it is presented.
- Channel drain:
  - A word is delivered when valid_salida[k] && ready_salida[k].
  - Without a simultaneous load, valid_salida[k] clears at the next edge.
- Simultaneous drain and load on the same channel:
  - The new word is loaded and valid_salida[k] stays 1, giving full throughput of 1 word/cycle per channel.
- Full channel:
  - When valid_salida[k]=1 and ready_salida[k]=0, a word targeting k sees ready_entrada=0.
  - The channel's data and valid are held unchanged until the word drains.
- Output gating:
  - salida channel k = data register k when valid_salida[k]=1, else 0. Invalid channels always read zero.
- Out-of-range selector (only possible when NUM_SALIDAS is not a power of two):
  - The word is accepted and dropped; no channel changes.
  - error_selector = 1 for exactly the next cycle, then returns to 0.
- enb = 0:
  - ready_entrada = 0 and no loads occur.
  - Held words still drain normally; error_selector cannot fire.
- valid_entrada = 0: no state change on the input side, regardless of ready_entrada.
- Ordering: words to the same channel leave in acceptance order. There is no ordering guarantee across channels.

Optional Feature:
- Macro: DEMUX_REG_CONTADORES_EN.
- Defined:
  - Adds output port contadores, NUM_SALIDAS*CONT_BITS wide; channel k is at bits [k*CONT_BITS +: CONT_BITS].
  - Counter k increments by 1 at the edge following each delivery on channel k.
  - The counter saturates at 2^CONT_BITS-1 and does not wrap. Reset clears it to 0.
- Not defined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package demux_pkg holds:
  - the clog2-based SEL_BITS derivation;
  - a slice-index helper for the flattened buses;
  - the CONT_BITS default.
- One sub-module, demux_canal:
  - contains the one-entry register, the valid flag, the load/drain priority logic and, under the macro, the saturating counter;
  - is instantiated NUM_SALIDAS times via generate.
- demux_reg top holds only the selector decode, ready_entrada and error_selector.

Test Plan:
- After reset, enb=1, all ready_salida=1. Send entrada=4'hA sel=2 -> next cycle valid_salida=4'b0100, channel 2 = 4'hA, all others 0; one cycle later valid_salida=0.
- Stall channel 1: ready_salida[1]=0, send 4'h3 then 4'h5 to sel=1 -> second word sees ready_entrada=0 and channel 1 holds 4'h3. A concurrent word 4'h7 to sel=0 is accepted. Release ready_salida[1] -> 4'h5 accepted; channel 1 shows 4'h5 one cycle later.
- Back-to-back streaming of 8 words to sel=3 with ready_salida[3]=1 -> ready_entrada stays 1 and valid_salida[3] stays 1 for 8 consecutive cycles, data in order.
- NUM_SALIDAS=3, send selector=3 with valid_entrada=1 -> ready_entrada=1, error_selector=1 for exactly one cycle, valid_salida unchanged.
- enb=0 with channel 0 holding 4'hC and ready_salida[0]=1 -> ready_entrada=0, channel 0 drains, no new loads. Assert reset while channel 2 is full -> all outputs 0 next cycle.
- With DEMUX_REG_CONTADORES_EN and CONT_BITS=2: deliver 5 words on channel 1 -> contadores channel 1 = 3 (saturated), all other channels 0.
